spgd_adc_accum: RTL and testbench

- ADC-side responder to the SPGD sequencer's acquisition handshake.
- When `ADC_EN` rises, it discards a programmable number of settling samples, then accumulates 2^k signed ADC samples.
- It registers the sum and the arithmetic-shift average, and raises `ADC_DONE`. `ADC_DONE` is held until the sequencer drops `ADC_EN`.
- Sits between the ADC data path and the SPGD FSM; feeds the J+/J- metric registers.

---
 rtl/spgd_pkg.sv | 25 ++
 rtl/spgd_cycle_counter.sv | 35 +++
 rtl/spgd_adc_accum.sv | 140 ++++++++++++++
 tb/tb_spgd_adc_accum.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD acquisition path: state encoding, default
// widths and the accumulation-exponent clamp.
package spgd_pkg;

   localparam int ADC_WIDTH = 14;
   localparam int MAX_LOG2  = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_ACCUM  = 2'b10,
      ST_DONE   = 2'b11
   } acc_state_t;

   function automatic logic [3:0] clamp_log2(input logic [3:0] k, input logic [3:0] k_max);
      logic [3:0] r;
      if (k > k_max) begin
         r = k_max;
      end else begin
         r = k;
      end
      return r;
   endfunction

endpackage

// File: rtl/spgd_cycle_counter.sv
// Loadable up-counter with synchronous clear and a terminal-match flag,
// shared by the settle and accumulate phases.
module spgd_cycle_counter #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] cmp_val,
   output logic             match
);

   logic [CNT_W-1:0] count_r;

   // count register: clear beats load beats increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (inc) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign match = (count_r == cmp_val);

endmodule

// File: rtl/spgd_adc_accum.sv
// ADC-side acquisition responder: discards S settling samples, sums 2^k signed
// samples, then holds the sum/average with ADC_DONE until ADC_EN drops.
module spgd_adc_accum #(
   parameter int ADC_WIDTH    = spgd_pkg::ADC_WIDTH,
   parameter int MAX_LOG2     = spgd_pkg::MAX_LOG2,
   parameter int SETTLE_WIDTH = 8,
   parameter int ACC_WIDTH    = ADC_WIDTH + MAX_LOG2
) (
   input  logic                        ADC_CLK,
   input  logic                        RST,
   input  logic                        ADC_EN,
   input  logic signed [ADC_WIDTH-1:0] ADC_DATA,
   input  logic [3:0]                  NUM_LOG2,
   input  logic [SETTLE_WIDTH-1:0]     SETTLE_CYCLES,
   output logic                        ADC_DONE,
   output logic signed [ACC_WIDTH-1:0] ADC_SUM,
   output logic signed [ADC_WIDTH-1:0] ADC_AVG,
   output logic                        BUSY,
   output logic [1:0]                  ACC_STATE
);

   import spgd_pkg::*;

   localparam int CNT_W = (SETTLE_WIDTH > MAX_LOG2) ? SETTLE_WIDTH : MAX_LOG2;

   acc_state_t                  state_r;
   acc_state_t                  state_nxt_s;
   logic [3:0]                  k_r;
   logic [SETTLE_WIDTH-1:0]     s_r;
   logic signed [ACC_WIDTH-1:0] acc_r;
   logic signed [ACC_WIDTH-1:0] sum_r;
   logic signed [ADC_WIDTH-1:0] avg_r;

   logic signed [ACC_WIDTH-1:0] data_ext_s;
   logic signed [ACC_WIDTH-1:0] sum_nxt_s;
   logic [CNT_W-1:0]            n_last_s;
   logic [CNT_W-1:0]            s_last_s;
   logic [CNT_W-1:0]            cnt_cmp_s;
   logic                        cnt_load_s;
   logic                        cnt_clr_s;
   logic                        cnt_inc_s;
   logic                        cnt_match_s;

   assign data_ext_s = {{(ACC_WIDTH-ADC_WIDTH){ADC_DATA[ADC_WIDTH-1]}}, ADC_DATA};
   assign sum_nxt_s  = acc_r + data_ext_s;
   // N-1 as a low-bit mask; wraps correctly when k equals the counter width
   assign n_last_s   = ~({CNT_W{1'b1}} << k_r);
   assign s_last_s   = CNT_W'(s_r) - CNT_W'(1);
   assign cnt_cmp_s  = (state_r == ST_SETTLE) ? s_last_s : n_last_s;

   spgd_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (ADC_CLK),
      .rst      (RST),
      .load     (cnt_load_s),
      .load_val ({CNT_W{1'b0}}),
      .clr      (cnt_clr_s),
      .inc      (cnt_inc_s),
      .cmp_val  (cnt_cmp_s),
      .match    (cnt_match_s)
   );

   // next-state and counter control
   always_comb begin
      state_nxt_s = state_r;
      cnt_load_s  = 1'b0;
      cnt_clr_s   = 1'b0;
      cnt_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ADC_EN) begin
               cnt_load_s  = 1'b1;
               state_nxt_s = (SETTLE_CYCLES != {SETTLE_WIDTH{1'b0}}) ? ST_SETTLE : ST_ACCUM;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!ADC_EN) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_match_s) begin
               cnt_clr_s   = 1'b1;
               state_nxt_s = ST_ACCUM;
            end else begin
               cnt_inc_s   = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (!ADC_EN) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_match_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               cnt_inc_s   = 1'b1;
            end
         end
         ST_DONE: begin
            if (!ADC_EN) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // state, latched configuration, accumulator and result registers
   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
         k_r     <= 4'd0;
         s_r     <= {SETTLE_WIDTH{1'b0}};
         acc_r   <= {ACC_WIDTH{1'b0}};
         sum_r   <= {ACC_WIDTH{1'b0}};
         avg_r   <= {ADC_WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && ADC_EN) begin
            k_r   <= clamp_log2(NUM_LOG2, 4'(MAX_LOG2));
            s_r   <= SETTLE_CYCLES;
            acc_r <= {ACC_WIDTH{1'b0}};
         end else if ((state_r == ST_ACCUM) && ADC_EN) begin
            acc_r <= sum_nxt_s;
            if (cnt_match_s) begin
               sum_r <= sum_nxt_s;
               avg_r <= ADC_WIDTH'(sum_nxt_s >>> k_r);
            end
         end
      end
   end

   assign ADC_DONE  = (state_r == ST_DONE);
   assign BUSY      = (state_r == ST_SETTLE) || (state_r == ST_ACCUM);
   assign ACC_STATE = state_r;
   assign ADC_SUM   = sum_r;
   assign ADC_AVG   = avg_r;

endmodule

// File: tb/tb_spgd_adc_accum.sv
// Scoreboard bench for spgd_adc_accum: runs push expected sum/avg, a monitor
// pops and compares on every rising ADC_DONE.
module tb_spgd_adc_accum;

   logic               adc_clk = 1'b0;
   logic               rst = 1'b1;
   logic               adc_en = 1'b0;
   logic signed [13:0] adc_data = 14'sd0;
   logic [3:0]         num_log2 = 4'd0;
   logic [7:0]         settle_cycles = 8'd0;
   logic               adc_done;
   logic signed [23:0] adc_sum;
   logic signed [13:0] adc_avg;
   logic               busy;
   logic [1:0]         acc_state;

   typedef struct {
      longint sum;
      longint avg;
      string  name;
   } exp_t;

   exp_t exp_q[$];
   int   samples[$];
   int   tests = 0;
   int   fails = 0;
   logic done_prev = 1'b0;

   spgd_adc_accum dut (
      .ADC_CLK       (adc_clk),
      .RST           (rst),
      .ADC_EN        (adc_en),
      .ADC_DATA      (adc_data),
      .NUM_LOG2      (num_log2),
      .SETTLE_CYCLES (settle_cycles),
      .ADC_DONE      (adc_done),
      .ADC_SUM       (adc_sum),
      .ADC_AVG       (adc_avg),
      .BUSY          (busy),
      .ACC_STATE     (acc_state)
   );

   always #5 adc_clk = ~adc_clk;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: every rising ADC_DONE must match the oldest expected result
   always @(negedge adc_clk) begin
      if (adc_done && !done_prev) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got sum %0d with no run outstanding, expected no ADC_DONE", adc_sum);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_sum"}, $signed(adc_sum), e.sum);
            check({e.name, "_avg"}, $signed(adc_avg), e.avg);
         end
      end
      done_prev <= adc_done;
   end

   // one full run using the samples queue (settle samples first)
   task automatic do_run(input string name, input int s, input int k_in, input int k_eff,
                         input longint esum, input longint eavg);
      int   total;
      exp_t e;
      total  = s + (1 << k_eff);
      e.sum  = esum;
      e.avg  = eavg;
      e.name = name;
      exp_q.push_back(e);
      @(negedge adc_clk);
      adc_en        = 1'b1;
      num_log2      = 4'(k_in);
      settle_cycles = 8'(s);
      @(posedge adc_clk);
      #1 check({name, "_busy_edge1"}, busy, 1);
      for (int i = 0; i < total; i++) begin
         @(negedge adc_clk);
         adc_data = 14'(samples[i]);
         // config changes mid-run must be ignored
         num_log2      = 4'd0;
         settle_cycles = 8'd0;
         if (i == total - 1) check({name, "_done_early"}, adc_done, 0);
      end
      @(posedge adc_clk);
      #1 check({name, "_done_at_edge"}, adc_done, 1);
   endtask

   task automatic release_en(input string name);
      @(negedge adc_clk);
      adc_en = 1'b0;
      @(posedge adc_clk);
      #1;
      check({name, "_done_fall"}, adc_done, 0);
      check({name, "_idle"}, acc_state, 0);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge adc_clk);
      @(negedge adc_clk);
      check("rst_done", adc_done, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", adc_sum, 0);
      check("rst_avg", adc_avg, 0);
      check("rst_state", acc_state, 0);
      rst = 1'b0;

      samples = '{100, 200, 300, 400};
      do_run("basic", 0, 2, 2, 1000, 250);
      release_en("basic");

      // reset asserted mid-ACCUM after 7 samples
      @(negedge adc_clk);
      adc_en = 1'b1; num_log2 = 4'd4; settle_cycles = 8'd0; adc_data = 14'sd50;
      @(posedge adc_clk);
      repeat (7) @(posedge adc_clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_done", adc_done, 0);
      check("midrst_busy", busy, 0);
      check("midrst_sum", adc_sum, 0);
      check("midrst_avg", adc_avg, 0);
      check("midrst_state", acc_state, 0);
      @(negedge adc_clk);
      rst = 1'b0;
      adc_en = 1'b0;

      samples.delete();
      for (int i = 0; i < 16; i++) samples.push_back(3);
      do_run("after_rst", 0, 4, 4, 48, 3);
      release_en("after_rst");

      samples = '{7, 7, 7, 10, 20};
      do_run("settle", 3, 1, 1, 30, 15);
      release_en("settle");

      samples = '{-5, -5, -5, -5, -5, -5, -5, -5};
      do_run("neg5", 0, 3, 3, -40, -5);
      release_en("neg5");

      samples.delete();
      for (int i = 0; i < 1024; i++) samples.push_back(-8192);
      do_run("fullscale", 0, 15, 10, -8388608, -8192);
      release_en("fullscale");

      samples = '{100, 200, 300, 400};
      do_run("basic2", 0, 2, 2, 1000, 250);
      release_en("basic2");

      // abort after 5 samples: no ADC_DONE, prior result kept
      @(negedge adc_clk);
      adc_en = 1'b1; num_log2 = 4'd4; settle_cycles = 8'd0; adc_data = 14'sd77;
      @(posedge adc_clk);
      repeat (5) @(posedge adc_clk);
      @(negedge adc_clk);
      adc_en = 1'b0;
      @(posedge adc_clk);
      #1;
      check("abort_state", acc_state, 0);
      check("abort_done", adc_done, 0);
      check("abort_sum", adc_sum, 1000);
      check("abort_avg", adc_avg, 250);

      samples = '{99, 99, 1, 2, 3, 4};
      do_run("post_abort", 2, 2, 2, 10, 2);
      release_en("post_abort");

      // handshake hold then re-arm
      samples = '{-1, 0};
      do_run("floor", 0, 1, 1, -1, -1);
      repeat (20) @(negedge adc_clk);
      check("hold_done", adc_done, 1);
      check("hold_state", acc_state, 3);
      check("hold_busy", busy, 0);
      release_en("hold");
      samples = '{1, 2, 3, 6};
      do_run("rearm", 0, 2, 2, 12, 3);
      release_en("rearm");

      repeat (3) @(negedge adc_clk);
      check("scoreboard_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: got no completion by time limit, expected bench end");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
